// File: rtl/sargantana_tag_array.sv
// Multi-way instruction-cache tag store with valid bits, post-reset init sweep, flush FSM and registered hit vector.
// Optional per-entry even parity over {vbit, tag} when SARGANTANA_TAG_PARITY_EN is defined (adds perr_o).
module sargantana_tag_array #(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned TAG_WIDTH  = 20,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [NUM_WAYS-1:0]           way_we_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [TAG_WIDTH-1:0]          tag_i,
    input  logic                          vbit_i,
    input  logic                          flush_i,
    output logic                          ready_o,
    output logic                          rvalid_o,
    output logic [NUM_WAYS*TAG_WIDTH-1:0] tag_o,
    output logic [NUM_WAYS-1:0]           vbit_o,
    output logic [NUM_WAYS-1:0]           hit_o,
    output logic                          busy_o
`ifdef SARGANTANA_TAG_PARITY_EN
    ,
    output logic [NUM_WAYS-1:0]           perr_o
`endif
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic init_c;
    logic flush_c;
    logic rd_acc_c;
    logic wr_acc_c;

    logic [NUM_WAYS*TAG_WIDTH-1:0] rd_tag_c;
    logic [NUM_WAYS-1:0]           rd_vld_c;
    logic [NUM_WAYS-1:0]           rd_hit_c;
`ifdef SARGANTANA_TAG_PARITY_EN
    logic [NUM_WAYS-1:0]           rd_perr_c;
`endif

    // Flush in IDLE takes priority over a simultaneous request.
    assign ready_o  = (state_q == ST_IDLE) && !flush_i;
    assign init_c   = (state_q == ST_INIT);
    assign flush_c  = (state_q == ST_FLUSH);
    assign rd_acc_c = req_i && ready_o && !we_i;
    assign wr_acc_c = req_i && ready_o && we_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = ADDR_WIDTH'(cnt_q + 1'b1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [TAG_WIDTH-1:0] tag_q [DEPTH];
        logic [DEPTH-1:0]     vld_q;
`ifdef SARGANTANA_TAG_PARITY_EN
        logic [DEPTH-1:0]     par_q;
`endif

        // Valid bits need a true reset so a mid-sweep reset leaves nothing stale visible.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                vld_q <= '0;
            end else if (flush_c) begin
                vld_q <= '0;
            end else if (init_c) begin
                vld_q[cnt_q] <= 1'b0;
            end else if (wr_acc_c && way_we_i[w]) begin
                vld_q[addr_i] <= vbit_i;
            end
        end

        // Tag storage behaves like SRAM: no reset, cleared by the init sweep.
        always_ff @(posedge clk_i) begin
            if (init_c) begin
                tag_q[cnt_q] <= '0;
            end else if (wr_acc_c && way_we_i[w]) begin
                tag_q[addr_i] <= tag_i;
            end
        end

`ifdef SARGANTANA_TAG_PARITY_EN
        // Flush drops valid 1->0, so toggle parity on those entries to stay consistent.
        always_ff @(posedge clk_i) begin
            if (init_c) begin
                par_q[cnt_q] <= 1'b0;
            end else if (flush_c) begin
                par_q <= par_q ^ vld_q;
            end else if (wr_acc_c && way_we_i[w]) begin
                par_q[addr_i] <= ^{vbit_i, tag_i};
            end
        end

        assign rd_perr_c[w] = ^{vld_q[addr_i], tag_q[addr_i], par_q[addr_i]};
        assign rd_hit_c[w]  = vld_q[addr_i] && (tag_q[addr_i] == tag_i) && !rd_perr_c[w];
`else
        assign rd_hit_c[w]  = vld_q[addr_i] && (tag_q[addr_i] == tag_i);
`endif
        assign rd_tag_c[w*TAG_WIDTH +: TAG_WIDTH] = tag_q[addr_i];
        assign rd_vld_c[w] = vld_q[addr_i];
    end

    // Read results are captured at accept and held until the next accepted read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_o <= 1'b0;
            tag_o    <= '0;
            vbit_o   <= '0;
            hit_o    <= '0;
            busy_o   <= 1'b1;
`ifdef SARGANTANA_TAG_PARITY_EN
            perr_o   <= '0;
`endif
        end else begin
            rvalid_o <= rd_acc_c;
            busy_o   <= (state_d != ST_IDLE);
            if (rd_acc_c) begin
                tag_o  <= rd_tag_c;
                vbit_o <= rd_vld_c;
                hit_o  <= rd_hit_c;
`ifdef SARGANTANA_TAG_PARITY_EN
                perr_o <= rd_perr_c;
`endif
            end
        end
    end

endmodule
